// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// gmii_tx_framer : GMII transmit framer with preamble/SFD insertion, IFG,
//                  underflow signalling and SFD timestamp capture.
// Revision       : 1.0
// ============================================================================
module gmii_tx_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        i_tx_enable,
   input  logic [8:0]  iv_data,
   input  logic        i_data_empty,
   output logic        o_data_rd,
   input  logic [18:0] timer,
   output logic [7:0]  ov_gmii_txd,
   output logic        o_gmii_tx_en,
   output logic        o_gmii_tx_er,
   output logic [18:0] ov_tx_ts,
   output logic        o_pkt_sent_pulse,
   output logic        o_fifo_underflow_pulse,
   output logic        o_drop_pulse,
   output logic [1:0]  ov_tx_state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_DATA     = 2'd2,
      S_IFG      = 2'd3
   } state_t;

   localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN);
   localparam logic [4:0] IFG_LAST = 5'(IFG_LEN - 1);

   state_t     state, state_nxt;
   logic [4:0] cnt, cnt_nxt;
   logic       first, first_nxt;
   logic       discard, discard_nxt;
   logic       tail_sent, tail_nxt;
   logic       pop;
   logic [7:0] txd_nxt;
   logic       en_nxt, er_nxt, ts_cap, uf_nxt, drop_nxt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      first_nxt   = first;
      discard_nxt = discard;
      tail_nxt    = 1'b0;
      pop         = 1'b0;
      txd_nxt     = 8'h00;
      en_nxt      = 1'b0;
      er_nxt      = 1'b0;
      ts_cap      = 1'b0;
      uf_nxt      = 1'b0;
      drop_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!i_data_empty) begin
               if (iv_data[8]) begin
                  if (i_tx_enable) begin
                     txd_nxt   = 8'h55;
                     en_nxt    = 1'b1;
                     cnt_nxt   = 5'd1;
                     state_nxt = S_PREAMBLE;
                  end
               end else begin
                  // orphan byte with no head: discard it to resync
                  pop      = 1'b1;
                  drop_nxt = 1'b1;
               end
            end
         end
         S_PREAMBLE: begin
            en_nxt = 1'b1;
            if (cnt == PRE_LAST) begin
               txd_nxt   = 8'hD5;
               ts_cap    = 1'b1;
               first_nxt = 1'b1;
               state_nxt = S_DATA;
            end else begin
               txd_nxt = 8'h55;
               cnt_nxt = cnt + 5'd1;
            end
         end
         S_DATA: begin
            en_nxt = 1'b1;
            if (i_data_empty) begin
               er_nxt      = 1'b1;
               uf_nxt      = 1'b1;
               discard_nxt = 1'b1;
               state_nxt   = S_IFG;
            end else begin
               pop       = 1'b1;
               txd_nxt   = iv_data[7:0];
               first_nxt = 1'b0;
               if (iv_data[8] && !first) begin
                  tail_nxt  = 1'b1;
                  cnt_nxt   = 5'd0;
                  state_nxt = S_IFG;
               end
            end
         end
         default: begin
            if (discard) begin
               // flush the rest of the broken packet, head included if unpopped
               if (!i_data_empty) begin
                  pop       = 1'b1;
                  first_nxt = 1'b0;
                  if (iv_data[8] && !first) begin
                     discard_nxt = 1'b0;
                     cnt_nxt     = 5'd0;
                  end
               end
            end else if (cnt == IFG_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + 5'd1;
            end
         end
      endcase
   end

   assign o_data_rd   = pop & ~reset;
   assign ov_tx_state = state;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state                  <= S_IDLE;
         cnt                    <= 5'd0;
         first                  <= 1'b0;
         discard                <= 1'b0;
         tail_sent              <= 1'b0;
         ov_gmii_txd            <= 8'h00;
         o_gmii_tx_en           <= 1'b0;
         o_gmii_tx_er           <= 1'b0;
         ov_tx_ts               <= 19'd0;
         o_pkt_sent_pulse       <= 1'b0;
         o_fifo_underflow_pulse <= 1'b0;
         o_drop_pulse           <= 1'b0;
      end else begin
         state                  <= state_nxt;
         cnt                    <= cnt_nxt;
         first                  <= first_nxt;
         discard                <= discard_nxt;
         tail_sent              <= tail_nxt;
         ov_gmii_txd            <= txd_nxt;
         o_gmii_tx_en           <= en_nxt;
         o_gmii_tx_er           <= er_nxt;
         o_pkt_sent_pulse       <= tail_sent;
         o_fifo_underflow_pulse <= uf_nxt;
         o_drop_pulse           <= drop_nxt;
         if (ts_cap) ov_tx_ts <= timer;
      end
   end

endmodule
`default_nettype wire
